// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event path.
// Consumed by btn_edge_detect and button_press_classifier.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } btn_state_t;

  localparam int LONG_CYCLES_DEF   = 1000;
  localparam int REPEAT_CYCLES_DEF = 250;

endpackage

// File: rtl/btn_edge_detect.sv
// Edge detector for a debounced level.
// The previous sample is registered; rise/fall are single-cycle pulses against it.
module btn_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule

// File: rtl/button_press_classifier.sv
// Turns a debounced level into press/short/long events and a press count.
// Optional auto-repeat in the long state is enabled by defining BTN_REPEAT_EN.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clean,
  output logic       press,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_evt,
  output logic       held,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] LONG_V = CNT_W'(LONG_CYCLES);

  btn_state_t       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             rise;
  logic             fall;

  btn_edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clean),
    .rise  (rise),
    .fall  (fall)
  );

  assign hold_nxt = hold_cnt + 1'b1;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_V = CNT_W'(REPEAT_CYCLES);

  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_nxt;

  assign rep_nxt = rep_cnt + 1'b1;
`else
  assign repeat_evt = 1'b0;
`endif

  // In PRESSED/LONG the previous sample was high, so fall == low sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
`ifdef BTN_REPEAT_EN
      rep_cnt     <= '0;
      repeat_evt  <= 1'b0;
`endif
    end else begin
      press       <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_evt  <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (rise) begin
            state       <= PRESSED;
            held        <= 1'b1;
            hold_cnt    <= CNT_W'(1);
            press       <= 1'b1;
            press_count <= press_count + 8'd1;
          end
        end
        PRESSED: begin
          if (fall) begin
            state       <= IDLE;
            held        <= 1'b0;
            short_press <= 1'b1;
          end else begin
            hold_cnt <= hold_nxt;
            if (hold_nxt == LONG_V) begin
              state      <= LONG;
              long_press <= 1'b1;
`ifdef BTN_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end
          end
        end
        LONG: begin
          if (fall) begin
            state <= IDLE;
            held  <= 1'b0;
          end
`ifdef BTN_REPEAT_EN
          else if (rep_nxt == REP_V) begin
            rep_cnt    <= '0;
            repeat_evt <= 1'b1;
          end else begin
            rep_cnt <= rep_nxt;
          end
`endif
        end
        default: begin
          state <= IDLE;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
